uart_cmd_ctrl: RTL and testbench

Command sequencer between UART_RX, the register file and UART_TX. Parses byte frames delivered by UART_RX, performs register writes/reads, and returns read data through the UART_TX handshake. Aborts frames on parity/framing errors or inter-byte timeout, and keeps a saturating error count for debug.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_cmd_timer.sv | 30 +++
 rtl/uart_cmd_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_TX_REQ
    } state_e;

    localparam logic [7:0] WR_CMD_DEF = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF = 8'hBB;
    localparam int         ERR_W      = 8;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte / read-return watchdog: counts while enabled, pulses expire on the last count.
module uart_cmd_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A clear in the same cycle masks expiry, so a byte arriving on the last count wins.
    assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser between UART_RX, the register file and UART_TX, with a saturating error counter.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    TIMEOUT_CYC = 4096,
    parameter logic [DATA_WIDTH-1:0] WR_CMD      = DATA_WIDTH'(WR_CMD_DEF),
    parameter logic [DATA_WIDTH-1:0] RD_CMD      = DATA_WIDTH'(RD_CMD_DEF)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_FRM_ERR,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic                  RF_WR_EN,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_RD_EN,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic [ERR_W-1:0]      ERR_CNT,
    output logic                  CTRL_BUSY
);

    state_e state;
    logic   armed;
    logic   accepted;
    logic   bad;
    logic   tmr_en;
    logic   tmr_clr;
    logic   tmr_expire;
    logic   timeout;
    logic   err_inc;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign accepted = RX_D_VLD && !RX_PAR_ERR && !RX_FRM_ERR;
    assign bad      = RX_D_VLD && (RX_PAR_ERR || RX_FRM_ERR);
    assign tmr_en   = (state == S_WR_ADDR) || (state == S_WR_DATA) ||
                      (state == S_RD_ADDR) || (state == S_RD_WAIT);
    // Every entry into a counting state happens on an RX byte, so clearing on RX_D_VLD
    // and while idle/transmitting also covers the clear-on-entry requirement.
    assign tmr_clr  = RX_D_VLD || !tmr_en;
    assign timeout  = tmr_expire && !((state == S_RD_WAIT) && RF_RD_VLD);
    assign CTRL_BUSY = (state != S_IDLE);

    uart_cmd_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    always_comb begin
        err_inc = 1'b0;
        case (state)
            S_IDLE:                         err_inc = bad ||
                                                      (accepted && (RX_P_DATA != WR_CMD) &&
                                                       (RX_P_DATA != RD_CMD));
            S_WR_ADDR, S_WR_DATA, S_RD_ADDR: err_inc = bad || timeout;
            S_RD_WAIT, S_TX_REQ:            err_inc = RX_D_VLD || timeout;
            default:                        err_inc = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            RF_ADDR    <= '0;
            RF_WR_EN   <= 1'b0;
            RF_WR_DATA <= '0;
            RF_RD_EN   <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            ERR_CNT    <= '0;
        end else begin
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            if (err_inc) ERR_CNT <= sat_inc(ERR_CNT);

            case (state)
                S_IDLE: begin
                    if (accepted && (RX_P_DATA == WR_CMD))      state <= S_WR_ADDR;
                    else if (accepted && (RX_P_DATA == RD_CMD)) state <= S_RD_ADDR;
                end
                S_WR_ADDR: begin
                    if (accepted) begin
                        RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= S_WR_DATA;
                    end else if (bad || timeout) begin
                        state <= S_IDLE;
                    end
                end
                S_WR_DATA: begin
                    if (accepted) begin
                        RF_WR_DATA <= RX_P_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= S_IDLE;
                    end else if (bad || timeout) begin
                        state <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (accepted) begin
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RF_RD_EN <= 1'b1;
                        state    <= S_RD_WAIT;
                    end else if (bad || timeout) begin
                        state <= S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    if (RF_RD_VLD) begin
                        TX_P_DATA <= RF_RD_DATA;
                        TX_D_VLD  <= 1'b1;
                        // A transmitter already busy must go idle and rise again before we accept it.
                        armed     <= !TX_BUSY;
                        state     <= S_TX_REQ;
                    end else if (timeout) begin
                        state <= S_IDLE;
                    end
                end
                S_TX_REQ: begin
                    if (TX_BUSY && armed) begin
                        TX_D_VLD <= 1'b0;
                        state    <= S_IDLE;
                    end else if (!TX_BUSY) begin
                        armed <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a 16-cycle timeout.
module tb_uart_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic       RX_PAR_ERR = 1'b0;
    logic       RX_FRM_ERR = 1'b0;
    logic [3:0] RF_ADDR;
    logic       RF_WR_EN;
    logic [7:0] RF_WR_DATA;
    logic       RF_RD_EN;
    logic [7:0] RF_RD_DATA = '0;
    logic       RF_RD_VLD = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY = 1'b0;
    logic [7:0] ERR_CNT;
    logic       CTRL_BUSY;

    int total = 0;
    int bad   = 0;

    uart_cmd_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .TIMEOUT_CYC(16),
        .WR_CMD     (8'hAA),
        .RD_CMD     (8'hBB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_P_DATA (RX_P_DATA),
        .RX_D_VLD  (RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR),
        .RX_FRM_ERR(RX_FRM_ERR),
        .RF_ADDR   (RF_ADDR),
        .RF_WR_EN  (RF_WR_EN),
        .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN  (RF_RD_EN),
        .RF_RD_DATA(RF_RD_DATA),
        .RF_RD_VLD (RF_RD_VLD),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .TX_BUSY   (TX_BUSY),
        .ERR_CNT   (ERR_CNT),
        .CTRL_BUSY (CTRL_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic perr, input logic ferr);
        RX_P_DATA  = b;
        RX_PAR_ERR = perr;
        RX_FRM_ERR = ferr;
        RX_D_VLD   = 1'b1;
        tick(1);
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_FRM_ERR = 1'b0;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_addr", RF_ADDR, 0);
        chk("rst_wr_en", RF_WR_EN, 0);
        chk("rst_rd_en", RF_RD_EN, 0);
        chk("rst_tx_vld", TX_D_VLD, 0);
        chk("rst_err", ERR_CNT, 0);
        chk("rst_busy", CTRL_BUSY, 0);
        tick(2);
        RST = 1'b1;
        tick(1);

        // write AA,05,3C
        send(8'hAA, 0, 0);
        chk("wr_busy", CTRL_BUSY, 1);
        send(8'h05, 0, 0);
        chk("wr_no_early", RF_WR_EN, 0);
        send(8'h3C, 0, 0);
        chk("wr_en", RF_WR_EN, 1);
        chk("wr_addr", RF_ADDR, 5);
        chk("wr_data", RF_WR_DATA, 8'h3C);
        tick(1);
        chk("wr_en_pulse", RF_WR_EN, 0);
        chk("wr_idle", CTRL_BUSY, 0);
        chk("wr_err", ERR_CNT, 0);

        // read BB,05 with TX idle on entry
        send(8'hBB, 0, 0);
        send(8'h05, 0, 0);
        chk("rd_en", RF_RD_EN, 1);
        chk("rd_addr", RF_ADDR, 5);
        tick(1);
        chk("rd_en_pulse", RF_RD_EN, 0);
        tick(1);
        RF_RD_DATA = 8'h3C;
        RF_RD_VLD  = 1'b1;
        tick(1);
        RF_RD_VLD  = 1'b0;
        chk("rd_tx_vld", TX_D_VLD, 1);
        chk("rd_tx_data", TX_P_DATA, 8'h3C);
        tick(3);
        chk("rd_tx_hold", TX_D_VLD, 1);
        TX_BUSY = 1'b1;
        tick(1);
        chk("rd_tx_drop", TX_D_VLD, 0);
        chk("rd_idle", CTRL_BUSY, 0);
        TX_BUSY = 1'b0;
        tick(1);

        // parity error mid-frame, unknown opcode, framing error mid-frame
        send(8'hAA, 0, 0);
        send(8'h05, 1, 0);
        chk("par_no_wr", RF_WR_EN, 0);
        chk("par_idle", CTRL_BUSY, 0);
        chk("par_err", ERR_CNT, 1);
        send(8'h55, 0, 0);
        chk("unk_err", ERR_CNT, 2);
        chk("unk_idle", CTRL_BUSY, 0);
        send(8'hBB, 0, 0);
        send(8'h05, 0, 1);
        chk("frm_no_rd", RF_RD_EN, 0);
        chk("frm_err", ERR_CNT, 3);

        // read with TX busy on entry and an overrun byte while waiting
        send(8'hBB, 0, 0);
        send(8'h06, 0, 0);
        tick(1);
        send(8'h77, 0, 0);
        chk("ovr_err", ERR_CNT, 4);
        chk("ovr_busy", CTRL_BUSY, 1);
        TX_BUSY    = 1'b1;
        RF_RD_DATA = 8'h5A;
        RF_RD_VLD  = 1'b1;
        tick(1);
        RF_RD_VLD  = 1'b0;
        chk("pre_tx_vld", TX_D_VLD, 1);
        chk("pre_tx_data", TX_P_DATA, 8'h5A);
        tick(2);
        chk("pre_hold_busy", TX_D_VLD, 1);
        TX_BUSY = 1'b0;
        tick(1);
        chk("pre_hold_low", TX_D_VLD, 1);
        TX_BUSY = 1'b1;
        tick(1);
        chk("pre_tx_drop", TX_D_VLD, 0);
        chk("pre_idle", CTRL_BUSY, 0);
        TX_BUSY = 1'b0;
        tick(1);

        // timeout after AA: still waiting on the 16th silent cycle, idle after it
        send(8'hAA, 0, 0);
        tick(15);
        chk("tmo_pending", CTRL_BUSY, 1);
        tick(1);
        chk("tmo_idle", CTRL_BUSY, 0);
        chk("tmo_err", ERR_CNT, 5);
        chk("tmo_no_wr", RF_WR_EN, 0);

        // byte on cycle 15, then a byte on the expiry cycle itself
        send(8'hAA, 0, 0);
        tick(14);
        send(8'h07, 0, 0);
        chk("late_busy", CTRL_BUSY, 1);
        tick(15);
        send(8'h99, 0, 0);
        chk("edge_wr_en", RF_WR_EN, 1);
        chk("edge_addr", RF_ADDR, 7);
        chk("edge_data", RF_WR_DATA, 8'h99);
        chk("edge_err", ERR_CNT, 5);

        // read-return timeout
        send(8'hBB, 0, 0);
        send(8'h09, 0, 0);
        tick(16);
        chk("rdtmo_idle", CTRL_BUSY, 0);
        chk("rdtmo_err", ERR_CNT, 6);
        chk("rdtmo_no_tx", TX_D_VLD, 0);

        // asynchronous reset while in WR_DATA
        send(8'hAA, 0, 0);
        send(8'h01, 0, 0);
        chk("pre_rst_addr", RF_ADDR, 1);
        #3;
        RST = 1'b0;
        #1;
        chk("arst_addr", RF_ADDR, 0);
        chk("arst_err", ERR_CNT, 0);
        chk("arst_busy", CTRL_BUSY, 0);
        tick(1);
        RST = 1'b1;
        tick(1);
        send(8'hAA, 0, 0);
        send(8'h01, 0, 0);
        send(8'hFF, 0, 0);
        chk("post_wr_en", RF_WR_EN, 1);
        chk("post_addr", RF_ADDR, 1);
        chk("post_data", RF_WR_DATA, 8'hFF);
        chk("post_err", ERR_CNT, 0);

        // error counter saturation
        for (int i = 0; i < 254; i++) send(8'h00, 1, 0);
        chk("sat_254", ERR_CNT, 254);
        send(8'h00, 0, 1);
        chk("sat_255", ERR_CNT, 255);
        for (int i = 0; i < 45; i++) send(8'h00, 1, 0);
        chk("sat_hold", ERR_CNT, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
